// File: rtl/card_game_ctrl.sv
// Sequencer for the 4x4 memory-card board: cursor movement, card flipping,
// pair comparison with a timed hold, match bookkeeping and the win state.
module card_game_ctrl #(
    parameter int HOLD_CYCLES = 50000000,
    parameter int TMR_W       = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic [47:0] layout,
    output logic [3:0]  cursor,
    output logic [15:0] enable,
    output logic [15:0] matched,
    output logic [7:0]  moves,
    output logic [3:0]  pairs,
    output logic        busy,
    output logic        win
);

    typedef enum logic [1:0] {PICK1, PICK2, SHOW, WIN} state_t;

    state_t            state;
    logic [15:0]       face_up;
    logic [3:0]        first;
    logic [3:0]        second;
    logic [TMR_W-1:0]  timer;

    logic [1:0]        row;
    logic [1:0]        col;
    logic [3:0]        target;
    logic [15:0]       tgt_bit;
    logic              ids_equal;

    // Move is resolved before the select so a same-cycle btn_sel acts on the new position.
    always_comb begin
        row = cursor[3:2];
        col = cursor[1:0];
        if (btn_up)         row = row - 2'd1;
        else if (btn_down)  row = row + 2'd1;
        else if (btn_left)  col = col - 2'd1;
        else if (btn_right) col = col + 2'd1;
        target  = {row, col};
        tgt_bit = 16'd1 << target;
    end

    assign ids_equal = (layout[3*first +: 3] == layout[3*second +: 3]);

    // NOTE: every register here is state, so all assignments are non-blocking;
    // blocking ones would let later statements see half-updated values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= PICK1;
            cursor  <= '0;
            face_up <= '0;
            enable  <= '0;
            matched <= '0;
            moves   <= '0;
            pairs   <= '0;
            busy    <= 1'b0;
            win     <= 1'b0;
            timer   <= '0;
            first   <= '0;
            second  <= '0;
        end else begin
            case (state)
                PICK1: begin
                    cursor <= target;
                    if (btn_sel && !matched[target]) begin
                        first   <= target;
                        face_up <= tgt_bit;
                        enable  <= matched | tgt_bit;
                        state   <= PICK2;
                    end
                end
                PICK2: begin
                    cursor <= target;
                    if (btn_sel && target != first && !matched[target]) begin
                        second  <= target;
                        face_up <= face_up | tgt_bit;
                        enable  <= enable | tgt_bit;
                        moves   <= (moves == 8'hFF) ? moves : moves + 8'd1;
                        timer   <= TMR_W'(HOLD_CYCLES - 1);
                        busy    <= 1'b1;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        face_up <= '0;
                        busy    <= 1'b0;
                        if (ids_equal) begin
                            matched <= matched | face_up;
                            pairs   <= pairs + 4'd1;
                            if (pairs == 4'd7) begin
                                enable <= '1;
                                win    <= 1'b1;
                                state  <= WIN;
                            end else begin
                                enable <= matched | face_up;
                                state  <= PICK1;
                            end
                        end else begin
                            enable <= matched;
                            state  <= PICK1;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WIN: begin
                    if (btn_sel) begin
                        matched <= '0;
                        enable  <= '0;
                        moves   <= '0;
                        pairs   <= '0;
                        cursor  <= '0;
                        win     <= 1'b0;
                        state   <= PICK1;
                    end
                end
                default: state <= PICK1;
            endcase
        end
    end

endmodule

// File: doc/card_game_ctrl.md
Name: card_game_ctrl

Overview:
- Sequencer for the 4x4 memory-card board: moves a selection cursor, flips cards face-up, compares the two flipped cards, holds them visible, then keeps them up (match) or hides them (miss).
- Drives the per-position enable of the 16 card renderers: enable=0 shows the card back, enable=1 shows the face.
- Tracks moves, matched pairs and the win condition.
- Sits between the debounced button pulses and the card drawing instances.

Parameters:
- HOLD_CYCLES, 50000000, number of clk cycles two flipped cards stay visible before resolution (1 s at 50 MHz).
- TMR_W, 26, timer width; must hold HOLD_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_up  in  1  one-cycle pulse, cursor row-1
- btn_down  in  1  one-cycle pulse, cursor row+1
- btn_left  in  1  one-cycle pulse, cursor col-1
- btn_right  in  1  one-cycle pulse, cursor col+1
- btn_sel  in  1  one-cycle pulse, flip card / restart
- layout  in  48  card id per position, 3 bits each; position p uses bits [3p+2:3p]; static during play
- cursor  out  4  selected position {row[1:0],col[1:0]}, same encoding as the card pos input
- enable  out  16  face-up vector, bit p drives card p's enable
- matched  out  16  positions already paired
- moves  out  8  completed pair attempts, saturating at 255
- pairs  out  4  matched pairs, 0..8
- busy  out  1  high in SHOW
- win  out  1  high in WIN

Behaviour:
- All outputs are registered and update on the clk edge after the triggering input.
- Reset: state=PICK1, cursor=0, enable=0, matched=0, moves=0, pairs=0, busy=0, win=0, timer=0. Reset mid-SHOW aborts the hold and hides every card.
- Cursor moves are accepted only in PICK1 and PICK2:
  - Each move is modulo 4 within its own axis. Row and column wrap independently; col 3 + right -> col 0 of the same row.
  - If several direction pulses arrive in one cycle, only one is applied, priority up > down > left > right.
  - A direction pulse and btn_sel in the same cycle: the move is applied first, and the selection acts on the new cursor.
- enable = face_up | matched. face_up is internal and holds at most 2 bits set.
- PICK1, on btn_sel:
  - If the target is already matched: ignored, stay in PICK1.
  - Otherwise: first=target, face_up[first]=1, go to PICK2.
- PICK2, on btn_sel:
  - If target==first or the target is matched: ignored.
  - Otherwise: second=target, face_up[second]=1, moves=min(moves+1,255), timer=HOLD_CYCLES-1, go to SHOW.
- SHOW:
  - busy=1. Buttons, including btn_sel, are ignored. Timer decrements once per cycle.
  - At timer==0 the pair is resolved; this is HOLD_CYCLES cycles after entering SHOW.
  - If layout[first]==layout[second]: matched[first] and matched[second] set, pairs+1.
  - Otherwise both face_up bits are cleared.
  - In either case face_up is cleared and busy drops.
  - Next state is WIN if the new pairs==8, else PICK1.
- WIN:
  - win=1, enable=all ones, direction buttons ignored.
  - btn_sel restarts: matched=0, enable=0, moves=0, pairs=0, cursor=0, win=0, go to PICK1.
- The layout is not checked for validity. Ids that do not form pairs can make WIN unreachable; this is acceptable.
- State encoding: PICK1, PICK2, SHOW, WIN. Any illegal state returns to PICK1 on the next clk.

Test Plan:
All tests use HOLD_CYCLES=4 and layout id(p)=p>>1, so pairs are (0,1),(2,3),...

1. Reset, then btn_right x5 -> cursor 0,1,2,3,0,1. Then btn_down x4 -> cursor returns to 1. Then up+left+right in one cycle -> cursor 13 (up wins).
2. Cursor 0, btn_sel -> enable=0x0001, state PICK2. btn_sel again at 0 -> ignored. btn_right, btn_sel -> enable=0x0003, busy=1, moves=1. Exactly 4 cycles later -> matched=0x0003, pairs=1, busy=0, enable=0x0003.
3. Select positions 2 and 4 (a miss) -> enable=0x0014 for 4 cycles, then enable=0; matched unchanged; moves increments.
4. During SHOW, pulse btn_sel and btn_right -> no change to cursor or enable. Assert reset during SHOW -> all outputs 0 the next cycle.
5. Play all 8 pairs -> pairs=8, win=1, enable=0xFFFF. btn_sel -> all counters 0 and state PICK1. Selecting a matched position in PICK1 mid-game -> ignored.
6. Force 260 misses -> moves saturates at 255.
